// File: rtl/cache_ctrl_wb_if.sv
// Pipeline/cache/memory control bundle for the write-back cache controller.
// master = environment (pipeline, tag array, memory), slave = controller.
interface cache_ctrl_wb_if #(
    parameter int unsigned IDX_W = 1,
    parameter int unsigned CNT_W = 32
);
    logic             req_valid;
    logic             req_we;
    logic             hit;
    logic             dirty;
    logic             mem_ready;
    logic             cpu_stall;
    logic             reg_write_enable;
    logic             cache_we;
    logic             cache_fill_sel;
    logic             mem_we;
    logic             mem_re;
    logic             mem_addr_sel;
    logic [IDX_W-1:0] word_idx;
    logic             busy;
    logic [CNT_W-1:0] miss_count;
    logic [CNT_W-1:0] wb_count;

    modport master (
        output req_valid, req_we, hit, dirty, mem_ready,
        input  cpu_stall, reg_write_enable, cache_we, cache_fill_sel,
               mem_we, mem_re, mem_addr_sel, word_idx, busy, miss_count, wb_count
    );

    modport slave (
        input  req_valid, req_we, hit, dirty, mem_ready,
        output cpu_stall, reg_write_enable, cache_we, cache_fill_sel,
               mem_we, mem_re, mem_addr_sel, word_idx, busy, miss_count, wb_count
    );
endinterface

// File: rtl/cache_ctrl_wb.sv
// Write-back, write-allocate data cache controller: hits served same cycle,
// misses write back a dirty victim line beat by beat, then fill from memory.
module cache_ctrl_wb #(
    parameter int unsigned MEM_LATENCY   = 4,
    parameter int unsigned LINE_WORDS    = 1,
    parameter int unsigned IDX_W         = 1,
    parameter int unsigned USE_MEM_READY = 0,
    parameter int unsigned CNT_W         = 32
) (
    input logic           clk,
    input logic           rst_b,
    cache_ctrl_wb_if.slave bus
);
    localparam int unsigned LAT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(MEM_LATENCY - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(LINE_WORDS - 1);

    typedef enum logic [1:0] {IDLE, WB, FILL} state_t;

    state_t           state, state_d;
    logic [LAT_W-1:0] lat_cnt, lat_cnt_d;
    logic [IDX_W-1:0] word_idx, word_idx_d;
    logic [CNT_W-1:0] miss_count, miss_count_d;
    logic [CNT_W-1:0] wb_count, wb_count_d;

    logic beat_done, last_word;
    logic stall_c, rwe_c, cwe_c, fsel_c, mwe_c, mre_c, asel_c;

    assign beat_done = (USE_MEM_READY != 0) ? bus.mem_ready : (lat_cnt == LAT_LAST);
    assign last_word = (word_idx == IDX_LAST);

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state      <= IDLE;
            lat_cnt    <= '0;
            word_idx   <= '0;
            miss_count <= '0;
            wb_count   <= '0;
        end else begin
            state      <= state_d;
            lat_cnt    <= lat_cnt_d;
            word_idx   <= word_idx_d;
            miss_count <= miss_count_d;
            wb_count   <= wb_count_d;
        end
    end

    always_comb begin
        state_d      = state;
        lat_cnt_d    = '0;
        word_idx_d   = word_idx;
        miss_count_d = miss_count;
        wb_count_d   = wb_count;
        stall_c      = 1'b0;
        rwe_c        = 1'b0;
        cwe_c        = 1'b0;
        fsel_c       = 1'b0;
        mwe_c        = 1'b0;
        mre_c        = 1'b0;
        asel_c       = 1'b0;
        case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    if (bus.hit) begin
                        rwe_c = !bus.req_we;
                        cwe_c = bus.req_we;
                    end else begin
                        stall_c      = 1'b1;
                        miss_count_d = miss_count + CNT_W'(1);
                        word_idx_d   = '0;
                        if (bus.dirty) begin
                            state_d    = WB;
                            wb_count_d = wb_count + CNT_W'(1);
                        end else begin
                            state_d = FILL;
                        end
                    end
                end
            end
            WB: begin
                stall_c   = 1'b1;
                mwe_c     = 1'b1;
                asel_c    = 1'b1;
                lat_cnt_d = beat_done ? '0 : lat_cnt + LAT_W'(1);
                if (beat_done) begin
                    word_idx_d = last_word ? '0 : word_idx + IDX_W'(1);
                    if (last_word) state_d = FILL;
                end
            end
            FILL: begin
                stall_c   = 1'b1;
                mre_c     = 1'b1;
                lat_cnt_d = beat_done ? '0 : lat_cnt + LAT_W'(1);
                if (beat_done) begin
                    cwe_c      = 1'b1;
                    fsel_c     = 1'b1;
                    word_idx_d = last_word ? '0 : word_idx + IDX_W'(1);
                    if (last_word) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Combinational outputs are forced low while reset is held.
    assign bus.cpu_stall        = rst_b & stall_c;
    assign bus.reg_write_enable = rst_b & rwe_c;
    assign bus.cache_we         = rst_b & cwe_c;
    assign bus.cache_fill_sel   = rst_b & fsel_c;
    assign bus.mem_we           = rst_b & mwe_c;
    assign bus.mem_re           = rst_b & mre_c;
    assign bus.mem_addr_sel     = rst_b & asel_c;
    assign bus.busy             = rst_b & (state != IDLE);
    assign bus.word_idx         = word_idx;
    assign bus.miss_count       = miss_count;
    assign bus.wb_count         = wb_count;
endmodule

// File: tb/tb_cache_ctrl_wb.sv
// Scoreboarded bench for cache_ctrl_wb: three configurations driven from one
// directed sequence; expected per-cycle outputs are queued with the stimulus.
module tb_cache_ctrl_wb;
    localparam int unsigned CNT_W = 32;

    typedef struct packed {
        logic       stall;
        logic       rwe;
        logic       cwe;
        logic       fsel;
        logic       mwe;
        logic       mre;
        logic       asel;
        logic       busy;
        logic [1:0] widx;
    } outs_t;

    typedef struct packed {
        logic  v;
        logic  we;
        logic  h;
        logic  d;
        logic  r;
        outs_t exp;
    } step_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_b;
    logic req_valid, req_we, hit, dirty, mem_ready;
    int   sel;
    int   checks = 0;
    int   failures = 0;
    int   step_no = 0;
    int   exp_miss[3];
    int   exp_wb[3];
    step_t sb[$];
    outs_t obs;

    cache_ctrl_wb_if #(.IDX_W(1), .CNT_W(CNT_W)) bus_a ();
    cache_ctrl_wb_if #(.IDX_W(2), .CNT_W(CNT_W)) bus_b ();
    cache_ctrl_wb_if #(.IDX_W(1), .CNT_W(CNT_W)) bus_c ();

    assign bus_a.req_valid = req_valid && (sel == 0);
    assign bus_b.req_valid = req_valid && (sel == 1);
    assign bus_c.req_valid = req_valid && (sel == 2);
    assign bus_a.mem_ready = mem_ready && (sel == 0);
    assign bus_b.mem_ready = mem_ready && (sel == 1);
    assign bus_c.mem_ready = mem_ready && (sel == 2);
    assign bus_a.req_we = req_we;
    assign bus_b.req_we = req_we;
    assign bus_c.req_we = req_we;
    assign bus_a.hit = hit;
    assign bus_b.hit = hit;
    assign bus_c.hit = hit;
    assign bus_a.dirty = dirty;
    assign bus_b.dirty = dirty;
    assign bus_c.dirty = dirty;

    cache_ctrl_wb #(.MEM_LATENCY(4), .LINE_WORDS(1), .IDX_W(1), .USE_MEM_READY(0), .CNT_W(CNT_W))
        u_a (.clk(clk), .rst_b(rst_b), .bus(bus_a));
    cache_ctrl_wb #(.MEM_LATENCY(4), .LINE_WORDS(4), .IDX_W(2), .USE_MEM_READY(0), .CNT_W(CNT_W))
        u_b (.clk(clk), .rst_b(rst_b), .bus(bus_b));
    cache_ctrl_wb #(.MEM_LATENCY(4), .LINE_WORDS(1), .IDX_W(1), .USE_MEM_READY(1), .CNT_W(CNT_W))
        u_c (.clk(clk), .rst_b(rst_b), .bus(bus_c));

    always_comb begin
        case (sel)
            0: obs = {bus_a.cpu_stall, bus_a.reg_write_enable, bus_a.cache_we, bus_a.cache_fill_sel,
                      bus_a.mem_we, bus_a.mem_re, bus_a.mem_addr_sel, bus_a.busy, 1'b0, bus_a.word_idx};
            1: obs = {bus_b.cpu_stall, bus_b.reg_write_enable, bus_b.cache_we, bus_b.cache_fill_sel,
                      bus_b.mem_we, bus_b.mem_re, bus_b.mem_addr_sel, bus_b.busy, bus_b.word_idx};
            default: obs = {bus_c.cpu_stall, bus_c.reg_write_enable, bus_c.cache_we, bus_c.cache_fill_sel,
                      bus_c.mem_we, bus_c.mem_re, bus_c.mem_addr_sel, bus_c.busy, 1'b0, bus_c.word_idx};
        endcase
    end

    task automatic check(input string tag, input logic [63:0] o, input logic [63:0] e);
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic check_cnt(input string tag);
        check({tag, "_miss_a"}, 64'(bus_a.miss_count), 64'(exp_miss[0]));
        check({tag, "_wb_a"},   64'(bus_a.wb_count),   64'(exp_wb[0]));
        check({tag, "_miss_b"}, 64'(bus_b.miss_count), 64'(exp_miss[1]));
        check({tag, "_wb_b"},   64'(bus_b.wb_count),   64'(exp_wb[1]));
        check({tag, "_miss_c"}, 64'(bus_c.miss_count), 64'(exp_miss[2]));
        check({tag, "_wb_c"},   64'(bus_c.wb_count),   64'(exp_wb[2]));
    endtask

    task automatic push(input logic v, input logic we, input logic h, input logic d,
                        input logic r, input outs_t e);
        step_t s;
        s = {v, we, h, d, r, e};
        sb.push_back(s);
    endtask

    // Expected timeline of one miss: IDLE miss cycle, optional write-back,
    // fill, then the replayed request (or idle if req_valid was dropped).
    task automatic gen_miss(input logic d, input logic we, input int words, input int beat,
                            input logic hs, input int drop_at);
        outs_t e;
        int    cyc;
        logic  v;
        e = '0;
        e.stall = 1'b1;
        push(1'b1, we, 1'b0, d, 1'b0, e);
        cyc = 1;
        if (d) begin
            for (int w = 0; w < words; w++) begin
                for (int c = 0; c < beat; c++) begin
                    v = !(drop_at >= 0 && cyc >= drop_at);
                    e = '0;
                    e.stall = 1'b1; e.mwe = 1'b1; e.asel = 1'b1; e.busy = 1'b1; e.widx = 2'(w);
                    push(v, we, 1'b0, d, hs && (c == beat - 1), e);
                    cyc++;
                end
            end
        end
        for (int w = 0; w < words; w++) begin
            for (int c = 0; c < beat; c++) begin
                v = !(drop_at >= 0 && cyc >= drop_at);
                e = '0;
                e.stall = 1'b1; e.mre = 1'b1; e.busy = 1'b1; e.widx = 2'(w);
                e.cwe = (c == beat - 1);
                e.fsel = (c == beat - 1);
                push(v, we, 1'b0, d, hs && (c == beat - 1), e);
                cyc++;
            end
        end
        v = !(drop_at >= 0 && cyc >= drop_at);
        e = '0;
        if (v) begin
            e.rwe = !we;
            e.cwe = we;
        end
        push(v, we, 1'b1, d, 1'b0, e);
    endtask

    // Pops up to n scoreboard entries: drive after posedge, compare at negedge.
    task automatic drain(input int n);
        step_t s;
        for (int i = 0; i < n && sb.size() > 0; i++) begin
            s = sb.pop_front();
            req_valid = s.v;
            req_we    = s.we;
            hit       = s.h;
            dirty     = s.d;
            mem_ready = s.r;
            @(negedge clk);
            check($sformatf("dut%0d_step%0d", sel, step_no), 64'(obs), 64'(s.exp));
            step_no++;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        outs_t e;
        for (int k = 0; k < 3; k++) begin
            exp_miss[k] = 0;
            exp_wb[k]   = 0;
        end
        sel = 0; req_valid = 1'b1; req_we = 1'b0; hit = 1'b1; dirty = 1'b1; mem_ready = 1'b1;
        rst_b = 1'b0;
        #3;
        check("reset_outs", 64'(obs), 64'(0));
        check_cnt("reset");
        repeat (2) @(posedge clk);
        #1;
        req_valid = 1'b0; hit = 1'b0; dirty = 1'b0; mem_ready = 1'b0;
        rst_b = 1'b1;
        @(posedge clk);
        #1;

        // Load hit, then store hit with a dirty victim (dirty ignored)
        sel = 0;
        e = '0; e.rwe = 1'b1;
        push(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, e);
        push(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        e = '0; e.cwe = 1'b1;
        push(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, e);
        drain(3);
        check_cnt("hits");

        // Clean load miss, one-word line
        gen_miss(1'b0, 1'b0, 1, 4, 1'b0, -1);
        drain(100);
        exp_miss[0]++;
        check_cnt("clean_miss");

        // Dirty store miss, four-word line
        sel = 1;
        gen_miss(1'b1, 1'b1, 4, 4, 1'b0, -1);
        drain(100);
        exp_miss[1]++; exp_wb[1]++;
        check_cnt("dirty_miss");

        // req_valid dropped during fill: fill still completes
        gen_miss(1'b0, 1'b0, 4, 4, 1'b0, 5);
        push(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        drain(100);
        exp_miss[1]++;
        check_cnt("drop_valid");

        // Handshake memory: mem_ready in IDLE ignored, then a 7-cycle beat
        sel = 2;
        push(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0);
        push(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        gen_miss(1'b0, 1'b0, 1, 7, 1'b1, -1);
        drain(100);
        exp_miss[2]++;
        check_cnt("handshake");

        // Reset in the second write-back beat
        sel = 1;
        gen_miss(1'b1, 1'b1, 4, 4, 1'b0, -1);
        drain(1 + 4 + 2);
        sb.delete();
        check("pre_reset_busy", 64'(bus_b.busy), 64'(1));
        #2;
        rst_b = 1'b0;
        #1;
        check("mid_reset_outs", 64'(obs), 64'(0));
        for (int k = 0; k < 3; k++) begin
            exp_miss[k] = 0;
            exp_wb[k]   = 0;
        end
        check_cnt("mid_reset");
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        rst_b = 1'b1;
        @(negedge clk);
        check("post_reset_outs", 64'(obs), 64'(0));
        @(posedge clk);
        #1;
        e = '0; e.rwe = 1'b1;
        push(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, e);
        drain(1);
        check_cnt("post_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
